// File: rtl/dmem_responder_if.sv
// dmem_responder_if: processor <-> data-memory bus used between the DCache
// controller (master) and dmem_responder (slave).
//   proc2mem_command  BUS_NONE / BUS_LOAD / BUS_STORE
//   proc2mem_addr     byte address, bits [2:0] ignored by the responder
//   proc2mem_data     store data
//   mem2proc_response tag granted this cycle (combinational), 0 = rejected
//   mem2proc_tag      tag completing this cycle (registered), 0 = none
//   mem2proc_data     load block for mem2proc_tag, 0 for stores / idle
//   outstanding_cnt   number of occupied responder slots
package dmem_bus_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;
endpackage

interface dmem_responder_if #(parameter int XLEN = 32);
    import dmem_bus_pkg::*;

    bus_command_t    proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [3:0]      mem2proc_response;
    logic [3:0]      mem2proc_tag;
    logic [63:0]     mem2proc_data;
    logic [3:0]      outstanding_cnt;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_tag, mem2proc_data, outstanding_cnt
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_tag, mem2proc_data, outstanding_cnt
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with a tagged,
// multi-slot in-flight table and an on-chip backing store.
//   clock  system clock
//   reset  synchronous, active-high; clears slots and outputs, not the store
//   bus    dmem_responder_if.slave (command in, response/tag/data/count out)
// Parameters: LATENCY (1..15), MAX_OUTSTANDING (1..15), ADDR_WORDS_LOG2.

// One in-flight transaction slot. Exposes its next-state view so the top can
// pick the return for the coming edge from post-edge state; that is what lets
// a tag be visible exactly LATENCY cycles after acceptance.
module dmem_slot #(
    parameter int LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        grant,
    input  logic        grant_store,
    input  logic [63:0] grant_data,
    input  logic        ret_sel,
    output logic        valid,
    output logic        nxt_valid,
    output logic        nxt_elig,
    output logic [63:0] nxt_data
);
    logic        done_q;
    logic [3:0]  cd_q;
    logic [63:0] data_q;
    logic        nxt_done;
    logic [3:0]  nxt_cd;

    always_comb begin
        nxt_valid = valid;
        nxt_done  = done_q;
        nxt_cd    = cd_q;
        nxt_data  = data_q;
        if (grant) begin
            // grant only reaches a free slot, so it never overlaps a free
            nxt_valid = 1'b1;
            nxt_done  = 1'b0;
            nxt_cd    = 4'(LATENCY - 1);
            nxt_data  = grant_store ? 64'h0 : grant_data;
        end else if (done_q) begin
            // presentation cycle is ending: release the slot
            nxt_valid = 1'b0;
            nxt_done  = 1'b0;
        end else if (valid && cd_q != 4'd0) begin
            nxt_cd = cd_q - 4'd1;
        end
        nxt_elig = nxt_valid && !nxt_done && (nxt_cd == 4'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid  <= 1'b0;
            done_q <= 1'b0;
            cd_q   <= 4'd0;
            data_q <= 64'h0;
        end else begin
            valid  <= nxt_valid;
            done_q <= nxt_done | ret_sel;
            cd_q   <= nxt_cd;
            data_q <= nxt_data;
        end
    end
endmodule

module dmem_responder
    import dmem_bus_pkg::*;
#(
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDR_WORDS_LOG2 = 8
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int WORDS = 2 ** ADDR_WORDS_LOG2;

    logic [63:0] mem [WORDS];

    logic [MAX_OUTSTANDING-1:0]       slot_valid;
    logic [MAX_OUTSTANDING-1:0]       slot_nxt_valid;
    logic [MAX_OUTSTANDING-1:0]       slot_nxt_elig;
    logic [MAX_OUTSTANDING-1:0]       slot_grant;
    logic [MAX_OUTSTANDING-1:0]       slot_ret_sel;
    logic [MAX_OUTSTANDING-1:0][63:0] slot_nxt_data;

    logic [ADDR_WORDS_LOG2-1:0] word_addr;
    logic [63:0] ld_data;
    logic        is_store;
    logic        free_hit;
    logic [3:0]  grant_idx;
    logic        accept;
    logic        ret_hit;
    logic [3:0]  ret_idx;
    logic [63:0] ret_data;
    logic [3:0]  cnt_n;
    logic        unused_addr;

    // upper address bits wrap, low three select bytes within the word
    assign word_addr   = bus.proc2mem_addr[ADDR_WORDS_LOG2+2:3];
    assign unused_addr = ^bus.proc2mem_addr;
    assign ld_data     = mem[word_addr];
    assign is_store    = (bus.proc2mem_command == BUS_STORE);

    // lowest-index free slot
    always_comb begin
        free_hit  = 1'b0;
        grant_idx = 4'd0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_hit  = 1'b1;
                grant_idx = 4'(i);
            end
        end
    end

    assign accept = !reset && (bus.proc2mem_command != BUS_NONE) && free_hit;
    assign bus.mem2proc_response = accept ? grant_idx + 4'd1 : 4'd0;

    genvar g;
    generate
        for (g = 0; g < MAX_OUTSTANDING; g++) begin : g_slot
            assign slot_grant[g]   = accept && (grant_idx == 4'(g));
            assign slot_ret_sel[g] = ret_hit && (ret_idx == 4'(g));
            dmem_slot #(.LATENCY(LATENCY)) u_slot (
                .clock      (clock),
                .reset      (reset),
                .grant      (slot_grant[g]),
                .grant_store(is_store),
                .grant_data (ld_data),
                .ret_sel    (slot_ret_sel[g]),
                .valid      (slot_valid[g]),
                .nxt_valid  (slot_nxt_valid[g]),
                .nxt_elig   (slot_nxt_elig[g]),
                .nxt_data   (slot_nxt_data[g])
            );
        end
    endgenerate

    // lowest-index slot eligible after this edge wins the single return
    always_comb begin
        ret_hit  = 1'b0;
        ret_idx  = 4'd0;
        ret_data = 64'h0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (slot_nxt_elig[i]) begin
                ret_hit  = 1'b1;
                ret_idx  = 4'(i);
                ret_data = slot_nxt_data[i];
            end
        end
    end

    always_comb begin
        cnt_n = 4'd0;
        for (int i = 0; i < MAX_OUTSTANDING; i++)
            cnt_n = cnt_n + 4'(slot_nxt_valid[i]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.mem2proc_tag    <= 4'd0;
            bus.mem2proc_data   <= 64'h0;
            bus.outstanding_cnt <= 4'd0;
        end else begin
            bus.mem2proc_tag    <= ret_hit ? ret_idx + 4'd1 : 4'd0;
            bus.mem2proc_data   <= ret_data;
            bus.outstanding_cnt <= cnt_n;
        end
    end

    // backing store is deliberately outside reset
    always_ff @(posedge clock) begin
        if (accept && is_store)
            mem[word_addr] <= bus.proc2mem_data;
    end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_bus_pkg::*;

    localparam int LAT   = 4;
    localparam int SLOTS = 3;
    localparam int AW    = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dmem_responder_if #(.XLEN(32)) bus_if ();

    dmem_responder #(
        .LATENCY        (LAT),
        .MAX_OUTSTANDING(SLOTS),
        .ADDR_WORDS_LOG2(AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model: per-tag acceptance cycle and return value, plus memory
    longint      acc     [SLOTS];
    logic [63:0] ret_val [SLOTS];
    logic [63:0] mem_m   [2**AW];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // one bus cycle: drive, compare all outputs against the model, advance model
    task automatic step(input bus_command_t cmd, input logic [31:0] addr,
                        input logic [63:0] data, input logic rst, output logic accepted);
        logic [3:0]  exp_tag, exp_resp, exp_cnt;
        logic [63:0] exp_data;
        logic [AW-1:0] w;
        @(negedge clock);
        reset = rst;
        bus_if.proc2mem_command = cmd;
        bus_if.proc2mem_addr    = addr;
        bus_if.proc2mem_data    = data;
        #1;
        exp_tag = 0; exp_data = 0; exp_cnt = 0; exp_resp = 0;
        for (int t = 0; t < SLOTS; t++) begin
            if (acc[t] + LAT == cyc) begin
                exp_tag  = 4'(t + 1);
                exp_data = ret_val[t];
            end
            if (acc[t] < cyc && cyc <= acc[t] + LAT) exp_cnt++;
        end
        if (!rst && cmd != BUS_NONE)
            for (int t = SLOTS - 1; t >= 0; t--)
                if (!(acc[t] < cyc && cyc <= acc[t] + LAT)) exp_resp = 4'(t + 1);
        check("response", 64'(bus_if.mem2proc_response), 64'(exp_resp));
        check("tag",      64'(bus_if.mem2proc_tag),      64'(exp_tag));
        check("data",     bus_if.mem2proc_data,          exp_data);
        check("count",    64'(bus_if.outstanding_cnt),   64'(exp_cnt));
        accepted = (exp_resp != 0);
        if (rst) begin
            for (int t = 0; t < SLOTS; t++) acc[t] = -100;
        end else if (accepted) begin
            w = addr[AW+2:3];
            acc[exp_resp-1] = cyc;
            if (cmd == BUS_STORE) begin
                mem_m[w] = data;
                ret_val[exp_resp-1] = 64'h0;
            end else begin
                ret_val[exp_resp-1] = mem_m[w];
            end
        end
        cyc++;
    endtask

    // retry a command until granted, bounded
    task automatic issue(input bus_command_t cmd, input logic [31:0] addr, input logic [63:0] data);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) step(cmd, addr, data, 1'b0, ok);
        if (!ok) begin
            failures++;
            $display("FAIL issue_timeout cycle %0d: got no grant expected a grant", cyc);
        end
    endtask

    task automatic idle(input int n);
        logic ok;
        for (int i = 0; i < n; i++) step(BUS_NONE, 32'h0, 64'h0, 1'b0, ok);
    endtask

    initial begin
        logic ok;
        logic [31:0] a;
        for (int t = 0; t < SLOTS; t++) begin
            acc[t] = -100;
            ret_val[t] = 64'h0;
        end
        reset = 1'b1;
        bus_if.proc2mem_command = BUS_NONE;
        bus_if.proc2mem_addr    = 32'h0;
        bus_if.proc2mem_data    = 64'h0;
        repeat (2) @(posedge clock);

        idle(5);

        // directed: store/load round trip, ignored low bits, address wrap
        issue(BUS_STORE, 32'h40, 64'hDEADBEEF_CAFEF00D);
        issue(BUS_LOAD,  32'h40, 64'h0);
        issue(BUS_LOAD,  32'h44, 64'h0);
        issue(BUS_STORE, 32'h800, 64'h0123_4567_89AB_CDEF);
        issue(BUS_LOAD,  32'h0, 64'h0);
        idle(8);
        check("wrap_mem", mem_m[0], 64'h0123_4567_89AB_CDEF);

        // initialise the words used by random loads
        for (int w = 0; w < 16; w++)
            issue(BUS_STORE, 32'(w) << 3, {$urandom(), $urandom()});
        idle(8);

        // randomized traffic with occasional mid-flight reset
        for (int i = 0; i < 2000; i++) begin
            bus_command_t c;
            int r;
            r = $urandom_range(0, 2);
            c = (r == 0) ? BUS_NONE : (r == 1) ? BUS_LOAD : BUS_STORE;
            a = ($urandom() & 32'hFFFF_F800) | (32'($urandom_range(0, 15)) << 3)
                | 32'($urandom_range(0, 7));
            step(c, a, {$urandom(), $urandom()}, ($urandom_range(0, 59) == 0), ok);
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
